smu_seq_trigger: RTL and testbench
==================================

Name: smu_seq_trigger

Overview:
Next-generation signal monitor unit. It runs M independent trigger channels over one K-bit observable bus. Each channel matches a programmable sequence of up to N masked compare stages, with a per-stage timeout, optional inversion, and a pulse or sticky trigger. It sits beside the existing SMU arrays, feeds the patch/control logic, and is configured through a simple per-channel write port.

Parameters:
N, 4, maximum sequence stages per channel (N>=2); SW=$clog2(N)
K, 8, observable input width
M, 4, number of parallel channels (M>=2); CW=$clog2(M)
T, 8, per-stage timeout counter width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
i  input  K  observable signal set
cfg_stage_we  input  1  write one stage entry {cmp,mask,inv,timeout} of channel cfg_ch, stage cfg_stage
cfg_ch  input  CW  target channel for either write
cfg_stage  input  SW  target stage index
cfg_cmp  input  K  compare value
cfg_mask  input  K  compare mask (1 = bit compared)
cfg_inv  input  1  invert stage match
cfg_timeout  input  T  non-match cycles allowed in stage (0 = infinite)
cfg_ctrl_we  input  1  write channel control {en,last,sticky} of cfg_ch
cfg_en  input  1  channel enable
cfg_last  input  SW  index of final stage (sequence length = last+1)
cfg_sticky  input  1  1 = sticky trigger, 0 = one-cycle pulse
trig_clr  input  M  per-channel sticky trigger clear
trigger  output  M  registered trigger per channel
smu_state  output  M*SW  current stage index, channel c at [c*SW +: SW]

Behaviour:
- Reset (async, immediate): all config regs 0 (en=0), all stages 0, timers 0, trigger 0, smu_state 0.
- Stage match: m = ((((i ^ cmp[s]) & mask[s]) == 0) ^ inv[s]). mask=0, inv=0 always matches.
- Per channel, evaluated every clk when en=1, with s the current stage:
  - m and s==last: trigger asserts next cycle; s<=0; timer<=0.
  - m and s<last: s<=s+1; timer<=0.
  - !m and s==0: hold; timer stays 0. Stage 0 never times out.
  - !m and s>0: if timeout[s]!=0 and timer==timeout[s]-1, then s<=0 and timer<=0; otherwise timer<=timer+1. Exactly timeout[s] non-match cycles are tolerated; a match on the cycle after the last tolerated one is evaluated at stage 0.
  - If last is greater than the highest written stage, the unwritten stages use their reset values and match always.
- Latency: trigger is high in the cycle after the clock edge on which the final stage matched. smu_state updates on the same edge.
- Pulse mode: trigger high exactly one cycle per completed sequence. Back-to-back sequences can produce triggers on consecutive cycles when last=0.
- Sticky mode: trigger is set on completion and held until trig_clr[c]. If trig_clr[c] and completion occur in the same cycle, set wins (trigger stays 1).
- en=0: s=0, timer=0, trigger=0. No evaluation takes place.
- cfg_ctrl_we to channel c: new control takes effect at the next edge. The same edge forces s=0, timer=0 and trigger[c]=0, and it overrides any match in that cycle.
- cfg_stage_we: updates one entry at the next edge. There is no FSM reset. The new values apply from the following cycle, including mid-sequence.
- Both write strobes in the same cycle are legal and apply independently.
- Writes to channel >= M or stage >= N are ignored.
- Timer width is T. cfg_timeout is unsigned; 2^T-1 is the maximum finite timeout.

Test Plan:
- Two-stage pulse (K=8, N=4, M=4, T=8): ch0 stage0 {A5,FF}, stage1 {3C,FF}, last=1, en=1. Drive i=A5 then 3C -> smu_state[0] goes 0,1,0; trigger[0]=1 for exactly the one cycle after the 3C cycle; other channels stay 0.
- Timeout: as above with stage1 timeout=3. Drive A5,00,00,00,3C -> state returns to 0 after the third 00; no trigger. Drive A5,00,00,3C -> trigger fires.
- Mask/invert: ch2 stage0 {80, mask 80, inv=1}, last=0. i=7F -> trigger[2] pulses; i=80 -> no trigger; i=00 held 3 cycles -> 3 consecutive pulses.
- Sticky/clear: ch1 sticky, one-stage {11,FF}. i=11 -> trigger[1] held high through 10 cycles of i=00. trig_clr[1] -> 0 next cycle. trig_clr[1] asserted together with i=11 -> stays 1.
- Control write mid-sequence: ch3 three stages, advanced to s=2. cfg_ctrl_we to ch3 while i matches stage2 -> smu_state=0, no trigger. A stage write mid-sequence changes the match from the next cycle.
- Async reset: assert rst between clock edges while ch0 is at s=1 and sticky ch1 is triggered -> trigger=0 and smu_state=0 immediately. After release, nothing fires until re-configured (en=0).

Source files
------------

// File: rtl/smu_seq_trigger.sv
// smu_seq_trigger: M independent sequence-trigger channels watching one
// K-bit observable bus. Each channel walks up to N masked compare stages,
// with per-stage timeout and inversion, producing a pulse or sticky trigger.
module smu_seq_trigger #(
    parameter int unsigned N  = 4,
    parameter int unsigned K  = 8,
    parameter int unsigned M  = 4,
    parameter int unsigned T  = 8,
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [K-1:0]    i,
    input  logic            cfg_stage_we,
    input  logic [CW-1:0]   cfg_ch,
    input  logic [SW-1:0]   cfg_stage,
    input  logic [K-1:0]    cfg_cmp,
    input  logic [K-1:0]    cfg_mask,
    input  logic            cfg_inv,
    input  logic [T-1:0]    cfg_timeout,
    input  logic            cfg_ctrl_we,
    input  logic            cfg_en,
    input  logic [SW-1:0]   cfg_last,
    input  logic            cfg_sticky,
    input  logic [M-1:0]    trig_clr,
    output logic [M-1:0]    trigger,
    output logic [M*SW-1:0] smu_state
);

    // Per-channel, per-stage compare table
    logic [K-1:0] r_cmp  [M][N];
    logic [K-1:0] r_mask [M][N];
    logic         r_inv  [M][N];
    logic [T-1:0] r_to   [M][N];

    // Per-channel control and sequencing state
    logic [M-1:0]  r_en;
    logic [M-1:0]  r_sticky;
    logic [M-1:0]  r_trig;
    logic [SW-1:0] r_last  [M];
    logic [SW-1:0] r_stage [M];
    logic [T-1:0]  r_timer [M];

    // Current-stage match, completion and selected timeout per channel
    logic [M-1:0]  w_match;
    logic [M-1:0]  w_done;
    logic [T-1:0]  w_to_sel [M];

    // Select the current stage entry and evaluate its match; a stage index
    // with no table entry behaves like a reset entry (always matches).
    always_comb begin
        w_match = '1;
        w_done  = '0;
        for (int unsigned c = 0; c < M; c++) begin
            w_to_sel[c] = '0;
            for (int unsigned s = 0; s < N; s++) begin
                if (r_stage[c] == SW'(s)) begin
                    w_match[c]  = ((((i ^ r_cmp[c][s]) & r_mask[c][s]) == '0) ^ r_inv[c][s]);
                    w_to_sel[c] = r_to[c][s];
                end
            end
            w_done[c] = w_match[c] && (r_stage[c] == r_last[c]);
        end
    end

    // Stage table writes; out-of-range channel/stage never matches any entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < M; c++) begin
                for (int unsigned s = 0; s < N; s++) begin
                    r_cmp[c][s]  <= '0;
                    r_mask[c][s] <= '0;
                    r_inv[c][s]  <= 1'b0;
                    r_to[c][s]   <= '0;
                end
            end
        end else if (cfg_stage_we) begin
            for (int unsigned c = 0; c < M; c++) begin
                for (int unsigned s = 0; s < N; s++) begin
                    if (cfg_ch == CW'(c) && cfg_stage == SW'(s)) begin
                        r_cmp[c][s]  <= cfg_cmp;
                        r_mask[c][s] <= cfg_mask;
                        r_inv[c][s]  <= cfg_inv;
                        r_to[c][s]   <= cfg_timeout;
                    end
                end
            end
        end
    end

    // Channel control writes and sequence advance; a control write to a
    // channel restarts it and takes priority over any match that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en     <= '0;
            r_sticky <= '0;
            r_trig   <= '0;
            for (int unsigned c = 0; c < M; c++) begin
                r_last[c]  <= '0;
                r_stage[c] <= '0;
                r_timer[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < M; c++) begin
                if (cfg_ctrl_we && cfg_ch == CW'(c)) begin
                    r_en[c]     <= cfg_en;
                    r_last[c]   <= cfg_last;
                    r_sticky[c] <= cfg_sticky;
                    r_stage[c]  <= '0;
                    r_timer[c]  <= '0;
                    r_trig[c]   <= 1'b0;
                end else if (!r_en[c]) begin
                    r_stage[c] <= '0;
                    r_timer[c] <= '0;
                    r_trig[c]  <= 1'b0;
                end else begin
                    if (w_match[c]) begin
                        r_timer[c] <= '0;
                        r_stage[c] <= w_done[c] ? '0 : r_stage[c] + 1'b1;
                    end else if (r_stage[c] != '0) begin
                        if (w_to_sel[c] != '0 && r_timer[c] == w_to_sel[c] - 1'b1) begin
                            r_stage[c] <= '0;
                            r_timer[c] <= '0;
                        end else begin
                            r_timer[c] <= r_timer[c] + 1'b1;
                        end
                    end
                    // Completion wins over a same-cycle clear in sticky mode
                    r_trig[c] <= w_done[c] | (r_sticky[c] & r_trig[c] & ~trig_clr[c]);
                end
            end
        end
    end

    assign trigger = r_trig;

    // Flatten per-channel stage indices onto the state bus
    for (genvar g = 0; g < M; g++) begin : g_state
        assign smu_state[g*SW +: SW] = r_stage[g];
    end

endmodule

// File: tb/tb_smu_seq_trigger.sv
// Self-checking bench for smu_seq_trigger: directed scenarios followed by a
// randomized phase, all compared against a behavioural channel model.
module tb_smu_seq_trigger;

    localparam int N  = 4;
    localparam int K  = 8;
    localparam int M  = 4;
    localparam int T  = 8;
    localparam int SW = 2;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [K-1:0]    i = '0;
    logic            cfg_stage_we = 1'b0;
    logic [CW-1:0]   cfg_ch = '0;
    logic [SW-1:0]   cfg_stage = '0;
    logic [K-1:0]    cfg_cmp = '0;
    logic [K-1:0]    cfg_mask = '0;
    logic            cfg_inv = 1'b0;
    logic [T-1:0]    cfg_timeout = '0;
    logic            cfg_ctrl_we = 1'b0;
    logic            cfg_en = 1'b0;
    logic [SW-1:0]   cfg_last = '0;
    logic            cfg_sticky = 1'b0;
    logic [M-1:0]    trig_clr = '0;
    logic [M-1:0]    trigger;
    logic [M*SW-1:0] smu_state;

    smu_seq_trigger #(.N(N), .K(K), .M(M), .T(T)) dut (
        .clk(clk), .rst(rst), .i(i),
        .cfg_stage_we(cfg_stage_we), .cfg_ch(cfg_ch), .cfg_stage(cfg_stage),
        .cfg_cmp(cfg_cmp), .cfg_mask(cfg_mask), .cfg_inv(cfg_inv),
        .cfg_timeout(cfg_timeout), .cfg_ctrl_we(cfg_ctrl_we), .cfg_en(cfg_en),
        .cfg_last(cfg_last), .cfg_sticky(cfg_sticky), .trig_clr(trig_clr),
        .trigger(trigger), .smu_state(smu_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: configuration tables and per-channel progress
    int mcmp [M][N];
    int mmask[M][N];
    int minv [M][N];
    int mto  [M][N];
    int men[M], mlast[M], mstk[M];
    int mst[M], mtim[M], mtrig[M];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < M; c++) begin
            men[c] = 0; mlast[c] = 0; mstk[c] = 0;
            mst[c] = 0; mtim[c] = 0; mtrig[c] = 0;
            for (int s = 0; s < N; s++) begin
                mcmp[c][s] = 0; mmask[c][s] = 0; minv[c][s] = 0; mto[c][s] = 0;
            end
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge
    task automatic model_step();
        int ns[M];
        int nt[M];
        int ntr[M];
        for (int c = 0; c < M; c++) begin
            int  s;
            bit  m;
            bit  done;
            s = mst[c];
            ns[c] = 0; nt[c] = 0; ntr[c] = 0;
            if (cfg_ctrl_we && int'(cfg_ch) == c) begin
                ns[c] = 0; nt[c] = 0; ntr[c] = 0;
            end else if (men[c] != 0) begin
                m = ((((int'(i) ^ mcmp[c][s]) & mmask[c][s]) == 0) != (minv[c][s] != 0));
                done = m && (s == mlast[c]);
                ns[c] = s;
                nt[c] = mtim[c];
                if (m) begin
                    nt[c] = 0;
                    ns[c] = done ? 0 : s + 1;
                end else if (s != 0) begin
                    if (mto[c][s] != 0 && mtim[c] == mto[c][s] - 1) begin
                        ns[c] = 0; nt[c] = 0;
                    end else begin
                        nt[c] = (mtim[c] + 1) % (1 << T);
                    end
                end
                if (done) ntr[c] = 1;
                else if (mstk[c] != 0 && mtrig[c] != 0 && !trig_clr[c]) ntr[c] = 1;
                else ntr[c] = 0;
            end
        end
        if (cfg_stage_we) begin
            mcmp[cfg_ch][cfg_stage]  = int'(cfg_cmp);
            mmask[cfg_ch][cfg_stage] = int'(cfg_mask);
            minv[cfg_ch][cfg_stage]  = int'(cfg_inv);
            mto[cfg_ch][cfg_stage]   = int'(cfg_timeout);
        end
        if (cfg_ctrl_we) begin
            men[cfg_ch]   = int'(cfg_en);
            mlast[cfg_ch] = int'(cfg_last);
            mstk[cfg_ch]  = int'(cfg_sticky);
        end
        for (int c = 0; c < M; c++) begin
            mst[c] = ns[c]; mtim[c] = nt[c]; mtrig[c] = ntr[c];
        end
    endtask

    task automatic cmp_model(input string tag);
        logic [M-1:0]    et;
        logic [M*SW-1:0] es;
        for (int c = 0; c < M; c++) begin
            int st;
            st = mst[c];
            et[c] = (mtrig[c] != 0);
            es[c*SW +: SW] = st[SW-1:0];
        end
        chk({tag, "_trig"}, 32'(trigger), 32'(et));
        chk({tag, "_state"}, 32'(smu_state), 32'(es));
    endtask

    // Advance one clock, update the model and compare #1 after the edge
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        cmp_model(tag);
    endtask

    task automatic drive(input logic [K-1:0] v, input string tag);
        i = v;
        step(tag);
    endtask

    task automatic wr_stage(input int ch, input int st, input logic [K-1:0] cmpv,
                            input logic [K-1:0] mskv, input logic invv, input logic [T-1:0] tov);
        cfg_stage_we = 1'b1;
        cfg_ch = CW'(ch); cfg_stage = SW'(st);
        cfg_cmp = cmpv; cfg_mask = mskv; cfg_inv = invv; cfg_timeout = tov;
        step("wrstage");
        cfg_stage_we = 1'b0;
    endtask

    task automatic wr_ctrl(input int ch, input logic env, input int lastv, input logic stk);
        cfg_ctrl_we = 1'b1;
        cfg_ch = CW'(ch); cfg_en = env; cfg_last = SW'(lastv); cfg_sticky = stk;
        step("wrctrl");
        cfg_ctrl_we = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset state
        #12;
        chk("reset_trig", 32'(trigger), 32'h0);
        chk("reset_state", 32'(smu_state), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Two-stage pulse on ch0
        wr_stage(0, 0, 8'hA5, 8'hFF, 1'b0, 8'd0);
        wr_stage(0, 1, 8'h3C, 8'hFF, 1'b0, 8'd0);
        wr_ctrl(0, 1'b1, 1, 1'b0);
        drive(8'h00, "p_idle");
        drive(8'hA5, "p_a5");
        chk("p_state1", 32'(smu_state[1:0]), 32'd1);
        drive(8'h3C, "p_3c");
        chk("p_trig", 32'(trigger), 32'h1);
        chk("p_state0", 32'(smu_state[1:0]), 32'd0);
        drive(8'h00, "p_after");
        chk("p_trig_gone", 32'(trigger), 32'h0);

        // Stage timeout of 3 on ch0 stage1
        wr_stage(0, 1, 8'h3C, 8'hFF, 1'b0, 8'd3);
        drive(8'hA5, "to_a5");
        drive(8'h00, "to_n1");
        drive(8'h00, "to_n2");
        chk("to_state_hold", 32'(smu_state[1:0]), 32'd1);
        drive(8'h00, "to_n3");
        chk("to_state_back", 32'(smu_state[1:0]), 32'd0);
        drive(8'h3C, "to_late");
        chk("to_no_trig", 32'(trigger[0]), 32'd0);
        drive(8'hA5, "to2_a5");
        drive(8'h00, "to2_n1");
        drive(8'h00, "to2_n2");
        drive(8'h3C, "to2_3c");
        chk("to_in_time_trig", 32'(trigger[0]), 32'd1);

        // Mask + invert on ch2, single stage
        wr_stage(2, 0, 8'h80, 8'h80, 1'b1, 8'd0);
        wr_ctrl(2, 1'b1, 0, 1'b0);
        drive(8'h7F, "mi_7f");
        chk("mi_7f_trig", 32'(trigger[2]), 32'd1);
        drive(8'h80, "mi_80");
        chk("mi_80_trig", 32'(trigger[2]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(8'h00, "mi_00");
            chk("mi_00_pulse", 32'(trigger[2]), 32'd1);
        end

        // Sticky trigger and clear on ch1
        wr_stage(1, 0, 8'h11, 8'hFF, 1'b0, 8'd0);
        wr_ctrl(1, 1'b1, 0, 1'b1);
        drive(8'h11, "st_set");
        chk("st_set_trig", 32'(trigger[1]), 32'd1);
        for (int k = 0; k < 10; k++) begin
            drive(8'h00, "st_hold");
            chk("st_hold_trig", 32'(trigger[1]), 32'd1);
        end
        trig_clr = 4'b0010;
        drive(8'h00, "st_clr");
        chk("st_clr_trig", 32'(trigger[1]), 32'd0);
        drive(8'h11, "st_clr_set");
        chk("st_set_wins", 32'(trigger[1]), 32'd1);
        trig_clr = '0;

        // Control write mid-sequence on ch3, then a stage rewrite mid-sequence
        wr_stage(3, 0, 8'h01, 8'hFF, 1'b0, 8'd0);
        wr_stage(3, 1, 8'h02, 8'hFF, 1'b0, 8'd0);
        wr_stage(3, 2, 8'h03, 8'hFF, 1'b0, 8'd0);
        wr_ctrl(3, 1'b1, 2, 1'b0);
        drive(8'h01, "cw_01");
        drive(8'h02, "cw_02");
        chk("cw_state2", 32'(smu_state[7:6]), 32'd2);
        i = 8'h03;
        wr_ctrl(3, 1'b1, 2, 1'b0);
        chk("cw_restart_state", 32'(smu_state[7:6]), 32'd0);
        chk("cw_restart_trig", 32'(trigger[3]), 32'd0);
        drive(8'h01, "sw_01");
        drive(8'h02, "sw_02");
        i = 8'h00;
        wr_stage(3, 2, 8'h04, 8'hFF, 1'b0, 8'd0);
        drive(8'h03, "sw_old");
        chk("sw_old_no_trig", 32'(trigger[3]), 32'd0);
        drive(8'h04, "sw_new");
        chk("sw_new_trig", 32'(trigger[3]), 32'd1);

        // Asynchronous reset between edges
        for (int k = 0; k < 5; k++) drive(8'h00, "ar_idle");
        drive(8'h11, "ar_11");
        drive(8'hA5, "ar_a5");
        chk("ar_pre_state", 32'(smu_state[1:0]), 32'd1);
        chk("ar_pre_trig", 32'(trigger[1]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("ar_trig", 32'(trigger), 32'h0);
        chk("ar_state", 32'(smu_state), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(8'hA5, "ar_post_a5");
        drive(8'h3C, "ar_post_3c");
        drive(8'h11, "ar_post_11");
        drive(8'h7F, "ar_post_7f");
        chk("ar_quiet", 32'(trigger), 32'h0);

        // Randomized configuration and traffic
        for (int c = 0; c < M; c++) wr_ctrl(c, 1'b1, $urandom_range(0, N-1), 1'($urandom_range(0, 1)));
        for (int n = 0; n < 3000; n++) begin
            int rc;
            int rs;
            rc = $urandom_range(0, M-1);
            rs = $urandom_range(0, N-1);
            if ($urandom_range(0, 3) == 0) i = K'($urandom);
            else i = K'(mcmp[rc][rs]);
            trig_clr = M'($urandom) & M'($urandom) & M'($urandom);
            cfg_stage_we = ($urandom_range(0, 19) == 0);
            cfg_ctrl_we  = ($urandom_range(0, 39) == 0);
            cfg_ch       = CW'($urandom_range(0, M-1));
            cfg_stage    = SW'($urandom_range(0, N-1));
            cfg_cmp      = K'($urandom);
            case ($urandom_range(0, 4))
                0: cfg_mask = 8'hFF;
                1: cfg_mask = 8'hF0;
                2: cfg_mask = 8'h0F;
                3: cfg_mask = 8'h00;
                default: cfg_mask = K'($urandom);
            endcase
            cfg_inv      = ($urandom_range(0, 4) == 0);
            cfg_timeout  = T'($urandom_range(0, 5));
            cfg_en       = ($urandom_range(0, 7) != 0);
            cfg_last     = SW'($urandom_range(0, N-1));
            cfg_sticky   = 1'($urandom_range(0, 1));
            step("rnd");
        end
        cfg_stage_we = 1'b0;
        cfg_ctrl_we  = 1'b0;
        trig_clr     = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
